// File: rtl/usb_rx_engine.sv
// ---------------------------------------------------------------------------
// usb_rx_engine
//   USB full-speed packet receiver. Synchronises raw D+/D-, recovers bit
//   timing from D+ transitions, NRZI-decodes, removes stuffed bits, checks
//   the SYNC pattern and pushes received bytes into a first-word fall-through
//   FIFO that the endpoint logic drains with r_enable.
//
//   Optional feature macro: USB_RX_PID_CHECK_EN
//     defined   -> first byte after SYNC must have byte[7:4] == ~byte[3:0];
//                  a bad PID sends the packet to the error state unwritten.
//     undefined -> PID byte is written like any other byte.
//
// Parameters
//   CLKS_PER_BIT  clocks per USB bit (even, >= 4)
//   FIFO_DEPTH    receive buffer depth in bytes (power of two, >= 2)
//
// Ports
//   clk       system clock, rising edge
//   n_rst     asynchronous active-low reset
//   d_plus    raw D+ line (idle high)
//   d_minus   raw D- line (idle low)
//   r_enable  pop head byte this cycle (ignored when empty)
//   r_data    FIFO head byte
//   empty     FIFO holds no bytes
//   full      FIFO holds FIFO_DEPTH bytes
//   count     FIFO occupancy
//   rcving    packet in progress
//   r_error   sticky packet error, cleared at next packet start
// ---------------------------------------------------------------------------
module usb_rx_engine #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          d_plus,
  input  logic                          d_minus,
  input  logic                          r_enable,
  output logic [7:0]                    r_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rcving,
  output logic                          r_error
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MID  = BW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERR
  } state_e;

  // Synchronisers; dp_last_q holds the previous synchronised D+ for edge detect
  logic dp_meta_q, dp_sync_q, dp_last_q;
  logic dm_meta_q, dm_sync_q;

  state_e          state_q,     state_d;
  logic [BW-1:0]   bit_cnt_q,   bit_cnt_d;
  logic            nrzi_prev_q, nrzi_prev_d;
  logic [2:0]      ones_q,      ones_d;
  logic [7:0]      shift_q,     shift_d;
  logic [2:0]      nbits_q,     nbits_d;
  logic            rcving_q,    rcving_d;
  logic            r_error_q,   r_error_d;
  logic            err_se0_q,   err_se0_d;
`ifdef USB_RX_PID_CHECK_EN
  logic            pid_first_q, pid_first_d;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]   count_q,     count_d;

  logic       dp_edge, dp_fall, sample, se0, line_j, rx_bit;
  logic [7:0] byte_next;
  logic       push, pop, push_ok, fifo_full;

  always_comb begin
    dp_edge   = dp_sync_q ^ dp_last_q;
    dp_fall   = dp_last_q & ~dp_sync_q;
    sample    = (bit_cnt_q == BIT_MID);
    se0       = ~dp_sync_q & ~dm_sync_q;
    line_j    = dp_sync_q & ~dm_sync_q;
    rx_bit    = (dp_sync_q == nrzi_prev_q);
    byte_next = {rx_bit, shift_q[7:1]};
    fifo_full = (count_q == CW'(FIFO_DEPTH));
  end

  // Receive state machine, bit timer, decoder and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    nrzi_prev_d = nrzi_prev_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    nbits_d     = nbits_q;
    rcving_d    = rcving_q;
    r_error_d   = r_error_q;
    err_se0_d   = err_se0_q;
`ifdef USB_RX_PID_CHECK_EN
    pid_first_d = pid_first_q;
`endif
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    push        = 1'b0;

    // Realign to every D+ transition so sampling stays mid-bit
    if (dp_edge || bit_cnt_q == BIT_LAST) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + BW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        nrzi_prev_d = 1'b1;
        ones_d      = '0;
        nbits_d     = '0;
        err_se0_d   = 1'b0;
        if (dp_fall) begin
          state_d   = ST_SYNC;
          rcving_d  = 1'b1;
          r_error_d = 1'b0;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (sample) begin
          nrzi_prev_d = dp_sync_q;
          if (se0) begin
            if (state_q == ST_DATA && nbits_q == 3'd0) begin
              state_d = ST_EOP;
            end else begin
              state_d   = ST_ERR;
              r_error_d = 1'b1;
            end
          end else if (ones_q == 3'd6) begin
            // Bit after six ones: a 0 is the stuffed bit, a 1 is illegal
            ones_d = '0;
            if (rx_bit) begin
              state_d   = ST_ERR;
              r_error_d = 1'b1;
            end
          end else begin
            ones_d  = rx_bit ? ones_q + 3'd1 : 3'd0;
            shift_d = byte_next;
            nbits_d = nbits_q + 3'd1;
            if (nbits_q == 3'd7) begin
              if (state_q == ST_SYNC) begin
                if (byte_next == 8'h80) begin
                  state_d = ST_DATA;
`ifdef USB_RX_PID_CHECK_EN
                  pid_first_d = 1'b1;
`endif
                end else begin
                  state_d   = ST_ERR;
                  r_error_d = 1'b1;
                end
              end else begin
`ifdef USB_RX_PID_CHECK_EN
                pid_first_d = 1'b0;
                if (pid_first_q && (byte_next[7:4] != ~byte_next[3:0])) begin
                  state_d   = ST_ERR;
                  r_error_d = 1'b1;
                end else begin
                  push = 1'b1;
                end
`else
                push = 1'b1;
`endif
              end
            end
          end
        end
      end

      ST_EOP: begin
        if (sample && line_j) begin
          state_d     = ST_IDLE;
          rcving_d    = 1'b0;
          nrzi_prev_d = 1'b1;
        end
      end

      ST_ERR: begin
        r_error_d = 1'b1;
        if (sample) begin
          if (se0) begin
            err_se0_d = 1'b1;
          end else if (line_j && err_se0_q) begin
            state_d     = ST_IDLE;
            rcving_d    = 1'b0;
            nrzi_prev_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    pop     = r_enable && (count_q != '0);
    push_ok = push && (!fifo_full || pop);
    if (push && !push_ok) begin
      r_error_d = 1'b1;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = byte_next;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta_q   <= 1'b1;
      dp_sync_q   <= 1'b1;
      dp_last_q   <= 1'b1;
      dm_meta_q   <= 1'b0;
      dm_sync_q   <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      nrzi_prev_q <= 1'b1;
      ones_q      <= '0;
      shift_q     <= '0;
      nbits_q     <= '0;
      rcving_q    <= 1'b0;
      r_error_q   <= 1'b0;
      err_se0_q   <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
      pid_first_q <= 1'b0;
`endif
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      dp_meta_q   <= d_plus;
      dp_sync_q   <= dp_meta_q;
      dp_last_q   <= dp_sync_q;
      dm_meta_q   <= d_minus;
      dm_sync_q   <= dm_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      nrzi_prev_q <= nrzi_prev_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      nbits_q     <= nbits_d;
      rcving_q    <= rcving_d;
      r_error_q   <= r_error_d;
      err_se0_q   <= err_se0_d;
`ifdef USB_RX_PID_CHECK_EN
      pid_first_q <= pid_first_d;
`endif
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign r_data  = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = fifo_full;
  assign count   = count_q;
  assign rcving  = rcving_q;
  assign r_error = r_error_q;

endmodule

// File: tb/tb_usb_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_engine
//   Directed bench for usb_rx_engine (CLKS_PER_BIT=8, FIFO_DEPTH=4). Packets
//   are NRZI-encoded with optional bit stuffing; every byte expected in the
//   FIFO is queued when the packet is sent and a monitor compares each popped
//   byte against the queue head. Status outputs are checked after each packet.
//   Extra PID test is included when USB_RX_PID_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_usb_rx_engine;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk      = 1'b0;
  logic       n_rst    = 1'b0;
  logic       d_plus   = 1'b1;
  logic       d_minus  = 1'b0;
  logic       r_enable = 1'b0;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       rcving;
  logic       r_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  logic [7:0] tx    [$];
  logic [7:0] mon_exp;
  logic       tx_level;
  int         tx_ones;

  usb_rx_engine #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .r_enable (r_enable),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .rcving   (rcving),
    .r_error  (r_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop is compared with the queue head
  always @(negedge clk) begin
    if (n_rst && r_enable && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected actual=0x%0h required=none", r_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (r_data !== mon_exp) begin
          failures++;
          $display("FAIL pop_data actual=0x%0h required=0x%0h", r_data, mon_exp);
        end
      end
    end
  end

  // Hold one line state for one bit time; entered and left at posedge+1
  task automatic line(input logic dp, input logic dm);
    d_plus  = dp;
    d_minus = dm;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic emit(input logic bitv, input logic stuff_en);
    if (!bitv) tx_level = ~tx_level;
    line(tx_level, ~tx_level);
    tx_ones = bitv ? tx_ones + 1 : 0;
    if (stuff_en && tx_ones == 6) begin
      tx_level = ~tx_level;
      line(tx_level, ~tx_level);
      tx_ones = 0;
    end
  endtask

  task automatic send_packet(input string name, input logic [7:0] sync_b, input logic stuff_en);
    logic [7:0] b;
    tx_level = 1'b1;
    tx_ones  = 0;
    for (int k = 0; k < 8; k++) emit(sync_b[k], stuff_en);
    check({name, "_rcving_mid"}, rcving, 1);
    foreach (tx[i]) begin
      b = tx[i];
      for (int k = 0; k < 8; k++) emit(b[k], stuff_en);
    end
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    line(1'b1, 1'b0);
    repeat (3) line(1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    r_enable = 1'b1;
    while (n < 4 * DEPTH) begin
      @(posedge clk);
      #1;
      if (empty) break;
      n++;
    end
    r_enable = 1'b0;
    check({name, "_all_bytes_seen"}, exp_q.size(), 0);
    check({name, "_empty_after"}, empty, 1);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_rcving", rcving, 0);
    check("rst_r_error", r_error, 0);
    check("rst_r_data", r_data, 8'h00);
    @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (4) line(1'b1, 1'b0);

    // Basic packet: PID + one data byte
    tx = '{8'hA5, 8'h3C};
    exp_q = '{8'hA5, 8'h3C};
    send_packet("basic", 8'h80, 1'b1);
    check("basic_count", count, 2);
    check("basic_r_error", r_error, 0);
    check("basic_rcving_end", rcving, 0);
    drain("basic");

    // Long runs of ones needing stuff bits
    tx = '{8'hA5, 8'hFF, 8'h7F};
    exp_q = '{8'hA5, 8'hFF, 8'h7F};
    send_packet("stuff", 8'h80, 1'b1);
    check("stuff_count", count, 3);
    check("stuff_r_error", r_error, 0);
    drain("stuff");

    // Same run without stuffing: error at the seventh one, PID already stored
    tx = '{8'hA5, 8'h7F, 8'hFF};
    exp_q = '{8'hA5};
    send_packet("nostuff", 8'h80, 1'b0);
    check("nostuff_r_error", r_error, 1);
    check("nostuff_count", count, 1);
    check("nostuff_rcving_end", rcving, 0);
    drain("nostuff");

    // Corrupt SYNC: nothing stored
    tx = '{8'hA5, 8'h3C};
    send_packet("badsync", 8'h40, 1'b1);
    check("badsync_r_error", r_error, 1);
    check("badsync_empty", empty, 1);
    check("badsync_rcving_end", rcving, 0);

    // Clean packet afterwards clears the sticky error
    tx = '{8'hA5, 8'h3C};
    exp_q = '{8'hA5, 8'h3C};
    send_packet("recover", 8'h80, 1'b1);
    check("recover_r_error", r_error, 0);
    check("recover_count", count, 2);
    drain("recover");

    // Overflow: fifth byte dropped with error
    tx = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = '{8'hA5, 8'h11, 8'h22, 8'h33};
    send_packet("ovf", 8'h80, 1'b1);
    check("ovf_full", full, 1);
    check("ovf_count", count, 4);
    check("ovf_r_error", r_error, 1);
    check("ovf_rcving_end", rcving, 0);
    drain("ovf");

`ifdef USB_RX_PID_CHECK_EN
    // Malformed PID rejected before writing
    tx = '{8'hA6, 8'h3C};
    send_packet("badpid", 8'h80, 1'b1);
    check("badpid_r_error", r_error, 1);
    check("badpid_empty", empty, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
